// File: rtl/bcd_subtractor_4digits_seq.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock, LSD first.
// Latency: done rises DIGITS edges after the accepting start edge (next edge if an operand nibble is > 9).
// Backpressure: start is ignored while busy; operands are latched on accept and results held until the next accept.
module bcd_subtractor_4digits_seq #(
    parameter int DIGITS = 4,
    localparam int W     = 4 * DIGITS,
    localparam int CW    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         invalid
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a_reg, b_reg;
    logic          borrow;
    logic [CW-1:0] cnt;

    logic          accept, bad, last, neg;
    logic [3:0]    a_nib, b_nib, digit;
    logic [4:0]    t;

    function automatic logic has_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        accept    = start && (state != S_RUN);
        bad       = has_bad(a) || has_bad(b);
        last      = (cnt == CW'(DIGITS - 1));
        a_nib     = a_reg[{cnt, 2'b00} +: 4];
        b_nib     = b_reg[{cnt, 2'b00} +: 4];
        // 5-bit wrap-around: bit 4 set means the digit went negative
        t         = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0, borrow};
        neg       = t[4];
        digit     = neg ? (t[3:0] + 4'd10) : t[3:0];
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = bad ? S_DONE : S_RUN;
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = accept ? (bad ? S_DONE : S_RUN) : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            bout    <= 1'b0;
            invalid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (state == S_RUN) begin
            diff[{cnt, 2'b00} +: 4] <= digit;
            borrow <= neg;
            cnt    <= cnt + 1'b1;
            if (last) begin
                bout <= neg;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            borrow  <= bin;
            cnt     <= '0;
            diff    <= '0;
            bout    <= 1'b0;
            invalid <= bad;
            busy    <= !bad;
            done    <= bad;
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_subtractor_4digits_seq.sv
// Directed bench for the digit-serial BCD subtractor: results, latency, handshake, reset abort.
module tb_bcd_subtractor_4digits_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        bin;
    logic        busy, done, bout, invalid;
    logic [15:0] diff;

    int errors = 0;
    int checks = 0;
    int lat;
    logic fb;
    logic saw;

    bcd_subtractor_4digits_seq #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .invalid(invalid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns just after the accepting posedge
    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
        a = va; b = vb; bin = vbin; start = 1'b1;
        @(posedge clk);
    endtask

    // returns at the negedge where done is seen; lat = edges after the call point
    task automatic wait_done(output int l, output logic first_busy);
        logic got;
        got = 1'b0;
        l = 0;
        first_busy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 0) first_busy = busy;
            if (done) begin
                got = 1'b1;
                break;
            end
            l++;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 16'h0000);
        check("rst_bout", bout, 0);
        check("rst_invalid", invalid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: plain subtraction, latency
        issue(16'h5678, 16'h1234, 1'b0);
        wait_done(lat, fb);
        check("t1_busy_first", fb, 1);
        check("t1_latency", lat, 4);
        check("t1_diff", diff, 16'h4444);
        check("t1_bout", bout, 0);
        check("t1_invalid", invalid, 0);
        check("t1_busy_at_done", busy, 0);
        @(negedge clk);
        check("t1_done_single", done, 0);
        check("t1_diff_hold", diff, 16'h4444);

        // 2: underflow wraps to ten's complement
        issue(16'h0000, 16'h0001, 1'b0);
        wait_done(lat, fb);
        check("t2_diff", diff, 16'h9999);
        check("t2_bout", bout, 1);

        // 3: borrow ripples across three digits
        @(negedge clk);
        issue(16'h1000, 16'h0001, 1'b1);
        wait_done(lat, fb);
        check("t3_diff", diff, 16'h0998);
        check("t3_bout", bout, 0);

        // 4: all nines with borrow in, then back-to-back start in the done cycle
        @(negedge clk);
        issue(16'h9999, 16'h9999, 1'b1);
        wait_done(lat, fb);
        check("t4a_diff", diff, 16'h9999);
        check("t4a_bout", bout, 1);
        issue(16'h0001, 16'h0000, 1'b0);
        wait_done(lat, fb);
        check("t4b_latency", lat, 4);
        check("t4b_diff", diff, 16'h0001);
        check("t4b_bout", bout, 0);

        // 5: invalid nibble in a, done on the next edge, result cleared
        @(negedge clk);
        issue(16'h12A4, 16'h0000, 1'b0);
        wait_done(lat, fb);
        check("t5_latency", lat, 0);
        check("t5_busy", fb, 0);
        check("t5_invalid", invalid, 1);
        check("t5_diff", diff, 16'h0000);
        check("t5_bout", bout, 0);

        // 5b: invalid nibble in b
        @(negedge clk);
        issue(16'h0005, 16'h000F, 1'b0);
        wait_done(lat, fb);
        check("t5b_invalid", invalid, 1);
        check("t5b_latency", lat, 0);

        // 5c: start during RUN is ignored
        @(negedge clk);
        issue(16'h0300, 16'h0150, 1'b0);
        @(negedge clk);
        a = 16'h9999; b = 16'h0001; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        wait_done(lat, fb);
        check("t5c_latency", lat, 2);
        check("t5c_diff", diff, 16'h0150);
        check("t5c_bout", bout, 0);
        check("t5c_invalid", invalid, 0);
        @(negedge clk);
        check("t5c_idle_done", done, 0);
        check("t5c_idle_busy", busy, 0);

        // 5d: exact zero with borrow in
        issue(16'h0500, 16'h0499, 1'b1);
        wait_done(lat, fb);
        check("t5d_diff", diff, 16'h0000);
        check("t5d_bout", bout, 0);

        // 6: reset mid-operation aborts without a done pulse
        @(negedge clk);
        issue(16'h5678, 16'h1234, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_diff", diff, 16'h0000);
        check("t6_bout", bout, 0);
        check("t6_invalid", invalid, 0);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("t6_no_done", saw, 0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h5678, 16'h1234, 1'b0);
        wait_done(lat, fb);
        check("t6_after_latency", lat, 4);
        check("t6_after_diff", diff, 16'h4444);
        check("t6_after_bout", bout, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
